// File: rtl/hora_bcd_a_bin_pkg.sv
// -----------------------------------------------------------------------------
// hora_bcd_a_bin_pkg
// Shared constants, FSM state type and the 12 h / 24 h hour mapping helper
// used by the BCD hour loader.
// -----------------------------------------------------------------------------
package hora_bcd_a_bin_pkg;

   localparam logic [6:0] HOUR_MAX = 7'd23;
   localparam logic [6:0] H12_MIN  = 7'd1;
   localparam logic [6:0] H12_MAX  = 7'd12;
   localparam logic [3:0] BCD_MAX  = 4'd9;

   localparam logic FMT_12H = 1'b1;
   localparam logic FMT_24H = 1'b0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CHECK = 2'd1,
      CONV  = 2'd2,
      HOLD  = 2'd3
   } state_e;

   // Maps a decimal hour value onto the 0..23 count.
   // In 12 h mode, 12 AM is midnight (0) and 12 PM is noon (12).
   function automatic logic [6:0] to_hour(input logic [6:0] v,
                                          input logic       fmt,
                                          input logic       pm);
      if (fmt == FMT_24H) begin
         return v;
      end
      if (v == H12_MAX) begin
         return pm ? H12_MAX : 7'd0;
      end
      return pm ? (v + 7'd12) : v;
   endfunction

endpackage

// File: rtl/hora_bcd_a_bin_if.sv
// -----------------------------------------------------------------------------
// hora_bcd_a_bin_if
// Valid/ready bus carrying a BCD hour in and a binary hour out.
//   in_valid/in_ready     : input handshake
//   digit1/digit0         : BCD tens/units
//   AM_PM, formato_hora   : 0 = AM / 1 = PM, 1 = 12 h / 0 = 24 h
//   out_valid/out_ready   : output handshake
//   hour_bin, err         : result and illegal-input flag
//   err_count             : saturating illegal-input tally
// master = producer of the BCD hour / consumer of the result; slave = loader.
// -----------------------------------------------------------------------------
interface hora_bcd_a_bin_if #(
   parameter int unsigned N     = 5,
   parameter int unsigned ERR_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       digit1;
   logic [3:0]       digit0;
   logic             AM_PM;
   logic             formato_hora;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     hour_bin;
   logic             err;
   logic [ERR_W-1:0] err_count;

   modport master (
      output in_valid, digit1, digit0, AM_PM, formato_hora, out_ready,
      input  in_ready, out_valid, hour_bin, err, err_count
   );

   modport slave (
      input  in_valid, digit1, digit0, AM_PM, formato_hora, out_ready,
      output in_ready, out_valid, hour_bin, err, err_count
   );
endinterface

// File: rtl/hora_bcd_a_bin_bcd2_a_bin.sv
// -----------------------------------------------------------------------------
// bcd2_a_bin
// Combinational two-digit BCD to binary: tens*10 + units as shift-adds.
//   tens, units : BCD digits (values above 9 wrap within 7 bits)
//   bin         : 7-bit binary value (0..99 for legal digits)
// Shared by the hour, minute and second loaders.
// -----------------------------------------------------------------------------
module bcd2_a_bin (
   input  logic [3:0] tens,
   input  logic [3:0] units,
   output logic [6:0] bin
);
   logic [6:0] t_ext;
   logic [6:0] u_ext;

   always_comb begin
      t_ext = {3'b000, tens};
      u_ext = {3'b000, units};
      bin   = (t_ext << 3) + (t_ext << 1) + u_ext;
   end
endmodule

// File: rtl/hora_bcd_a_bin.sv
// -----------------------------------------------------------------------------
// hora_bcd_a_bin
// Converts a BCD hour (12 h or 24 h) into a binary 0..23 hour count for the
// hour counter load path, with range checking and a saturating error tally.
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   bus    : hora_bcd_a_bin_if.slave (valid/ready in, valid/ready out)
// Sequence: IDLE (capture) -> CHECK (validate) -> CONV (convert) -> HOLD.
// Optional macro HORA_CLAMP_EN: illegal inputs yield a clamped hour instead
// of 0 (err and err_count behave the same either way).
// -----------------------------------------------------------------------------
module hora_bcd_a_bin
   import hora_bcd_a_bin_pkg::*;
#(
   parameter int unsigned N     = 5,
   parameter int unsigned ERR_W = 4
) (
   input  logic               clk,
   input  logic               reset,
   hora_bcd_a_bin_if.slave    bus
);

   state_e           state_q, state_d;
   logic [3:0]       d1_q, d1_d;
   logic [3:0]       d0_q, d0_d;
   logic             pm_q, pm_d;
   logic             fmt_q, fmt_d;
   logic             illegal_q, illegal_d;
   logic [N-1:0]     hour_q, hour_d;
   logic             err_q, err_d;
   logic             out_valid_q, out_valid_d;
   logic [ERR_W-1:0] err_count_q, err_count_d;

   // Digits clamped to 9 feed the converter. For legal inputs this is the
   // identity, so one converter serves both the range check and the result.
   logic [3:0] d1_c;
   logic [3:0] d0_c;
   logic [6:0] v_c;
   logic       range_bad;
   logic       illegal_now;
   logic [6:0] hour7;

`ifdef HORA_CLAMP_EN
   function automatic logic [6:0] clamp_val(input logic [6:0] v,
                                            input logic       fmt);
      if (fmt == FMT_24H) begin
         return (v > HOUR_MAX) ? HOUR_MAX : v;
      end
      return ((v < H12_MIN) || (v > H12_MAX)) ? H12_MAX : v;
   endfunction
`endif

   bcd2_a_bin u_bcd2_a_bin (
      .tens  (d1_c),
      .units (d0_c),
      .bin   (v_c)
   );

   always_comb begin
      d1_c = (d1_q > BCD_MAX) ? BCD_MAX : d1_q;
      d0_c = (d0_q > BCD_MAX) ? BCD_MAX : d0_q;
      if (fmt_q == FMT_24H) begin
         range_bad = (v_c > HOUR_MAX);
      end else begin
         range_bad = (v_c < H12_MIN) || (v_c > H12_MAX);
      end
      illegal_now = (d1_q > BCD_MAX) || (d0_q > BCD_MAX) || range_bad;
   end

   always_comb begin
      state_d     = state_q;
      d1_d        = d1_q;
      d0_d        = d0_q;
      pm_d        = pm_q;
      fmt_d       = fmt_q;
      illegal_d   = illegal_q;
      hour_d      = hour_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      err_count_d = err_count_q;
      hour7       = '0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               d1_d    = bus.digit1;
               d0_d    = bus.digit0;
               pm_d    = bus.AM_PM;
               fmt_d   = bus.formato_hora;
               state_d = CHECK;
            end
         end
         CHECK: begin
            illegal_d = illegal_now;
            state_d   = CONV;
         end
         CONV: begin
`ifdef HORA_CLAMP_EN
            hour7 = to_hour(clamp_val(v_c, fmt_q), fmt_q, pm_q);
`else
            hour7 = illegal_q ? 7'd0 : to_hour(v_c, fmt_q, pm_q);
`endif
            hour_d      = N'(hour7);
            err_d       = illegal_q;
            out_valid_d = 1'b1;
            if (illegal_q && (err_count_q != '1)) begin
               err_count_d = err_count_q + 1'b1;
            end
            state_d = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         d1_q        <= '0;
         d0_q        <= '0;
         pm_q        <= 1'b0;
         fmt_q       <= 1'b0;
         illegal_q   <= 1'b0;
         hour_q      <= '0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         err_count_q <= '0;
      end else begin
         state_q     <= state_d;
         d1_q        <= d1_d;
         d0_q        <= d0_d;
         pm_q        <= pm_d;
         fmt_q       <= fmt_d;
         illegal_q   <= illegal_d;
         hour_q      <= hour_d;
         err_q       <= err_d;
         out_valid_q <= out_valid_d;
         err_count_q <= err_count_d;
      end
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = out_valid_q;
      bus.hour_bin  = hour_q;
      bus.err       = err_q;
      bus.err_count = err_count_q;
   end

endmodule

// File: tb/tb_hora_bcd_a_bin.sv
// -----------------------------------------------------------------------------
// tb_hora_bcd_a_bin
// Table-driven check of the BCD hour loader with a result scoreboard, plus
// hand-written sequences for output stall, saturation and mid-flight reset.
// -----------------------------------------------------------------------------
module tb_hora_bcd_a_bin;

   localparam int unsigned N       = 5;
   localparam int unsigned ERR_W   = 4;
   localparam int          CNT_MAX = (1 << ERR_W) - 1;

   typedef struct {
      logic       fmt;
      logic       pm;
      logic [3:0] d1;
      logic [3:0] d0;
      int         hour;
      int         hour_clamp;
      bit         err;
   } vec_t;

   typedef struct {
      int hour;
      bit err;
      int cnt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;

   hora_bcd_a_bin_if #(.N(N), .ERR_W(ERR_W)) bus ();

   hora_bcd_a_bin #(.N(N), .ERR_W(ERR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int   n_pass = 0;
   int   n_total = 0;
   int   exp_cnt = 0;
   exp_t sb[$];
   vec_t vecs[14];

   task automatic chk(input string name, input int act, input int exp_v);
      n_total++;
      if (act == exp_v) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
      end
   endtask

   function automatic int pick_hour(input vec_t v);
`ifdef HORA_CLAMP_EN
      return v.hour_clamp;
`else
      return v.hour;
`endif
   endfunction

   // One transaction: drive, accept, push expectation, wait for the result,
   // compare against the scoreboard head. If out_ready is high the result is
   // consumed on the first HOLD edge and that drop is checked too.
   task automatic run_txn(input vec_t v, input string tag);
      int   cyc;
      exp_t e;
      @(negedge clk);
      chk({tag, " in_ready"}, int'(bus.in_ready), 1);
      bus.formato_hora = v.fmt;
      bus.AM_PM        = v.pm;
      bus.digit1       = v.d1;
      bus.digit0       = v.d0;
      bus.in_valid     = 1'b1;
      @(posedge clk);
      if (v.err && exp_cnt != CNT_MAX) exp_cnt++;
      sb.push_back('{pick_hour(v), v.err, exp_cnt});
      #1;
      // Scramble inputs after capture; the in-flight result must not change.
      bus.in_valid     = 1'b0;
      bus.formato_hora = ~v.fmt;
      bus.AM_PM        = ~v.pm;
      bus.digit1       = 4'hF;
      bus.digit0       = 4'hF;
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!bus.out_valid) begin
         chk({tag, " timeout"}, 0, 1);
         sb.delete();
         return;
      end
      chk({tag, " latency"}, cyc, 2);
      e = sb.pop_front();
      chk({tag, " hour_bin"}, int'(bus.hour_bin), e.hour);
      chk({tag, " err"}, int'(bus.err), int'(e.err));
      chk({tag, " err_count"}, int'(bus.err_count), e.cnt);
      if (bus.out_ready) begin
         @(posedge clk);
         #1;
         chk({tag, " out_valid drop"}, int'(bus.out_valid), 0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (got running, expected done)");
      $fatal(1);
   end

   initial begin
      vec_t v;
      //            fmt   pm    d1     d0     hour clamp err
      vecs[0]  = '{1'b0, 1'b0, 4'd2, 4'd3, 23, 23, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 4'd1, 4'd2,  0,  0, 1'b0};
      vecs[2]  = '{1'b1, 1'b1, 4'd1, 4'd2, 12, 12, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 4'd1, 4'd1, 23, 23, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 4'd0, 4'd1,  1,  1, 1'b0};
      vecs[5]  = '{1'b0, 1'b1, 4'd0, 4'd0,  0,  0, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 4'd1, 4'd9, 19, 19, 1'b0};
      vecs[7]  = '{1'b1, 1'b1, 4'd0, 4'd5, 17, 17, 1'b0};
      vecs[8]  = '{1'b0, 1'b0, 4'd2, 4'd4,  0, 23, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 4'd0, 4'd0,  0,  0, 1'b1};
      vecs[10] = '{1'b1, 1'b1, 4'd0, 4'hA,  0, 21, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 4'd1, 4'd3,  0, 12, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 4'hA, 4'd0,  0, 23, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 4'd9, 4'd9,  0, 23, 1'b1};

      reset            = 1'b1;
      bus.in_valid     = 1'b0;
      bus.digit1       = '0;
      bus.digit0       = '0;
      bus.AM_PM        = 1'b0;
      bus.formato_hora = 1'b0;
      bus.out_ready    = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset in_ready", int'(bus.in_ready), 1);
      chk("reset out_valid", int'(bus.out_valid), 0);
      chk("reset hour_bin", int'(bus.hour_bin), 0);
      chk("reset err", int'(bus.err), 0);
      chk("reset err_count", int'(bus.err_count), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         run_txn(vecs[i], $sformatf("vec%0d", i));
      end

      // Push the tally past its ceiling.
      v = '{1'b0, 1'b0, 4'd2, 4'd4, 0, 23, 1'b1};
      for (int i = 0; i < 12; i++) begin
         run_txn(v, $sformatf("sat%0d", i));
      end
      chk("sat err_count", int'(bus.err_count), CNT_MAX);

      // Consumer stalls for 5 cycles; a competing in_valid must be ignored.
      bus.out_ready = 1'b0;
      v = '{1'b0, 1'b0, 4'd1, 4'd5, 15, 15, 1'b0};
      run_txn(v, "stall");
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.in_valid     = 1'b1;
         bus.formato_hora = 1'b0;
         bus.digit1       = 4'd0;
         bus.digit0       = 4'd7;
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d out_valid", i), int'(bus.out_valid), 1);
         chk($sformatf("stall%0d hour_bin", i), int'(bus.hour_bin), 15);
         chk($sformatf("stall%0d in_ready", i), int'(bus.in_ready), 0);
      end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall release out_valid", int'(bus.out_valid), 0);
      chk("stall release in_ready", int'(bus.in_ready), 1);
      repeat (3) @(posedge clk);
      #1;
      chk("stall no ghost result", int'(bus.out_valid), 0);

      // Reset while in CONV discards the result and clears the tally.
      @(negedge clk);
      bus.formato_hora = 1'b0;
      bus.digit1       = 4'd2;
      bus.digit0       = 4'd4;
      bus.in_valid     = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("rst conv out_valid", int'(bus.out_valid), 0);
      chk("rst conv err_count", int'(bus.err_count), 0);
      chk("rst conv in_ready", int'(bus.in_ready), 1);
      chk("rst conv hour_bin", int'(bus.hour_bin), 0);
      exp_cnt = 0;
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("rst conv discarded", int'(bus.out_valid), 0);
      run_txn(v, "post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
